// File: rtl/apb_slave.sv
// APB3 completer with four 32-bit storage registers in a 16-byte window at BASE_ADDR.
// Every access completes with exactly one wait state. An address outside the window, or
// one that is not word-aligned, completes with pslverr set and leaves the registers alone.
module apb_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] regs_q [4];
  logic [31:0] regs_d [4];
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic        access;
  logic        hit;
  logic [1:0]  index;

  assign access = psel & penable;
  assign hit    = (paddr[31:4] == BASE_ADDR[31:4]) && (paddr[1:0] == 2'b00);
  assign index  = paddr[3:2];

  // Next-state logic: the access is performed only on the IDLE->ACK edge, so holding
  // penable in ACK cannot repeat a write or change the returned data.
  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d  = ACK;
          pready_d = 1'b1;
          if (hit) begin
            pslverr_d = 1'b0;
            if (pwrite) begin
              regs_d[index] = pwdata;
            end else begin
              prdata_d = regs_q[index];
            end
          end else begin
            prdata_d  = 32'h0;
            pslverr_d = 1'b1;
          end
        end
      end
      ACK: begin
        if (!access) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  // State and register update; reset abandons any transfer in flight without writing.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= IDLE;
      regs_q[0] <= 32'h0;
      regs_q[1] <= 32'h0;
      regs_q[2] <= 32'h0;
      regs_q[3] <= 32'h0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: a reference model predicts each response when the
// transfer is issued, and a monitor pops and compares it when pready rises.
module tb_apb_slave;

  localparam logic [31:0] BASE = 32'h7000_0000;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        scb [$];
  exp_t        cur;
  logic [31:0] model [4];
  logic [31:0] lastRdata;
  logic        prevReady = 1'b0;
  int          checks = 0;
  int          errors = 0;

  apb_slave #(.BASE_ADDR(BASE)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  // Free-running bus clock.
  always #5 pclk = ~pclk;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Monitor: compare the predicted response at the rising edge of pready and keep it
  // compared for as long as the completer holds pready.
  always @(negedge pclk) begin
    if (pready === 1'b1 && prevReady !== 1'b1) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedReady actual=1 required=0");
      end else begin
        cur = scb.pop_front();
        checkOutput("rdata", prdata, cur.rdata);
        checkOutput("slverr", {31'h0, pslverr}, {31'h0, cur.err});
      end
    end else if (pready === 1'b1) begin
      checkOutput("holdRdata", prdata, cur.rdata);
      checkOutput("holdSlverr", {31'h0, pslverr}, {31'h0, cur.err});
    end
    prevReady = pready;
  end

  // One full APB transfer; the model decides the response from the address rules.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input int holdExtra);
    exp_t e;
    bit   inWindow;
    int   idx;
    inWindow = (addr >= BASE) && (addr < BASE + 32'd16) && (addr % 4 == 0);
    idx = int'((addr - BASE) / 4);
    if (!inWindow) begin
      lastRdata = 32'h0;
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      if (wr) model[idx] = data;
      else    lastRdata  = model[idx];
    end
    e.rdata = lastRdata;
    scb.push_back(e);

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    checkOutput("setupNoReady", {31'h0, pready}, 32'h0);
    penable = 1'b1;
    @(posedge pclk); #1;
    checkOutput("latency", {31'h0, pready}, 32'h1);
    repeat (holdExtra) @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    checkOutput("readyDrop", {31'h0, pready}, 32'h0);
    checkOutput("slverrDrop", {31'h0, pslverr}, 32'h0);
  endtask

  task automatic readAll();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, BASE + 32'(4 * i), 32'h0, 0);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    lastRdata = 32'h0;
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("resetReady", {31'h0, pready}, 32'h0);
    checkOutput("resetSlverr", {31'h0, pslverr}, 32'h0);
    checkOutput("resetRdata", prdata, 32'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, BASE + 32'h0, 32'd6, 0);
    applyStimulus(1'b0, BASE + 32'h0, 32'h0, 0);
    applyStimulus(1'b1, BASE + 32'h4, 32'h0B14_07E9, 0);
    applyStimulus(1'b0, BASE + 32'h4, 32'h0, 0);
    applyStimulus(1'b1, BASE + 32'h8, 32'h6170_6861, 0);
    applyStimulus(1'b1, BASE + 32'hC, 32'h676C_7573, 0);
    readAll();

    $display("[TB] illegal addresses");
    applyStimulus(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b1, BASE + 32'h2, 32'hCAFE_F00D, 0);
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 0);
    applyStimulus(1'b0, BASE + 32'h2, 32'h0, 0);
    readAll();

    $display("[TB] extended access phase");
    applyStimulus(1'b1, BASE + 32'h8, 32'h1234_5678, 3);
    applyStimulus(1'b0, BASE + 32'h8, 32'h0, 3);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, 3));
      else if (sel == 7) a = BASE + 32'($urandom_range(0, 15) | 1);
      else if (sel == 8) a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 63));
      else               a = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
    end
    readAll();

    $display("[TB] reset during access");
    applyStimulus(1'b1, BASE + 32'h0, 32'hFFFF_FFFF, 0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE; pwdata = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    penable = 1'b1; presetn = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; presetn = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    lastRdata = 32'h0;
    checkOutput("resetMidReady", {31'h0, pready}, 32'h0);
    checkOutput("resetMidRdata", prdata, 32'h0);
    @(posedge pclk); #1;
    readAll();

    repeat (3) @(posedge pclk);
    checkOutput("scoreboardEmpty", 32'(scb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
